// File: rtl/core_pkg.sv
// core_pkg: shared RV32I opcodes, sequencer state encoding and next-PC source encodings
package core_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_REG   = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} seq_state_t;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ALUI, OP_ALU};
  endfunction
endpackage

// File: rtl/core_seq.sv
// core_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter and sticky halt
module core_seq
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted
);
  seq_state_t state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic is_store, is_branch, is_mem, br_fire, st_fire;
  assign is_store  = opcode == OP_STORE;
  assign is_branch = opcode == OP_BRANCH;
  assign is_mem    = is_store || opcode == OP_LOAD;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = is_legal(opcode) ? S_EXEC : S_HALT;
      S_EXEC:   state_d = is_branch ? S_FETCH : is_mem ? S_MEM : S_WB;
      S_MEM:    state_d = !dmem_ready ? S_MEM : is_store ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end
  assign imem_req  = state_q == S_FETCH;
  assign ir_we     = imem_req && imem_ready;
  assign dmem_req  = state_q == S_MEM;
  assign dmem_we   = dmem_req && is_store;
  assign mdr_we    = dmem_req && dmem_ready && !is_store;
  assign rf_we     = state_q == S_WB;
  assign br_fire   = state_q == S_EXEC && is_branch;
  assign st_fire   = dmem_req && dmem_ready && is_store;
  assign pc_we     = rf_we || br_fire || st_fire;
  assign retire    = pc_we;
  assign halted    = state_q == S_HALT;
  assign pc_sel    = rf_we ? (opcode == OP_JAL ? PC_IMM : opcode == OP_JALR ? PC_REG : PC_PLUS4)
                   : (br_fire && br_taken) ? PC_IMM : PC_PLUS4;
  assign instret_d = instret_q + CNT_W'(retire);
  assign instret   = instret_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: instruction-level model expanded into per-cycle expectations, checked every cycle
module tb_core_seq;
  localparam int W = 4;
  localparam logic [10:0] IREQ = 11'h400, IRWE = 11'h200, DREQ = 11'h100, DWE = 11'h080,
                          MDR = 11'h040, RF = 11'h020, PCWE = 11'h010, RET = 11'h008,
                          SEL2 = 11'h004, SEL1 = 11'h002, HLT = 11'h001;
  localparam logic [6:0] ALU = 7'b0110011, ALUI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                         ST = 7'b0100011, SYS = 7'b1110011;
  logic clk = 0, rst_n = 0, br_taken = 0, imem_ready = 0, dmem_ready = 0;
  logic [6:0] opcode = '0, cur_op = '0;
  logic imem_req, dmem_req, dmem_we, ir_we, mdr_we, rf_we, pc_we, retire, halted;
  logic [1:0] pc_sel;
  logic [W-1:0] instret;
  logic [10:0] exp_v = '0;
  logic [W-1:0] exp_i = '0, cnt = '0;
  logic chk_en = 0;
  int pin_i = -1, nxt_i = -1, pin_n = -1, nxt_n = -1, pin_act = 0, nxt_act = 0;
  int checks = 0, errors = 0, n = 0;
  wire [10:0] act_v = {imem_req, ir_we, dmem_req, dmem_we, mdr_we, rf_we, pc_we, retire, pc_sel, halted};
  always #5 clk = ~clk;
  core_seq #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .retire(retire), .instret(instret), .halted(halted)
  );
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs @%0t op=%b got %b want %b", $time, opcode, act_v, exp_v);
      end
      checks++;
      if (instret !== exp_i) begin
        errors++;
        $display("FAIL instret @%0t got %0d want %0d", $time, instret, exp_i);
      end
      if (pin_i >= 0) begin
        checks++;
        if (instret !== W'(pin_i)) begin
          errors++;
          $display("FAIL pin_instret @%0t got %0d want %0d", $time, instret, pin_i);
        end
      end
      if (pin_n >= 0) begin
        checks++;
        if (pin_act != pin_n) begin
          errors++;
          $display("FAIL pin_latency @%0t got %0d want %0d", $time, pin_act, pin_n);
        end
      end
    end
  end
  task automatic cyc(input logic rn, input logic ir, input logic dr, input logic bt, input logic [10:0] e);
    @(posedge clk);
    #1;
    rst_n = rn;
    opcode = cur_op;
    imem_ready = ir;
    dmem_ready = dr;
    br_taken = bt;
    exp_v = e;
    exp_i = cnt;
    cnt = cnt + W'(e[3]);
    pin_i = nxt_i;
    nxt_i = -1;
    pin_n = nxt_n;
    pin_act = nxt_act;
    nxt_n = -1;
    chk_en = 1;
  endtask
  task automatic instr(input logic [6:0] op, input int wi, input int wd, input logic bt, output int len);
    logic legal;
    legal = op inside {ALU, ALUI, LUI, AUIPC, JAL, JALR, BR, LD, ST};
    cur_op = op;
    len = 0;
    for (int k = 0; k < wi; k++) begin cyc(1, 0, 1, 0, IREQ); len++; end
    cyc(1, 1, 0, 0, IREQ | IRWE); len++;
    cyc(1, 1, 1, 0, '0); len++;
    if (!legal) return;
    if (op == BR) begin
      cyc(1, 1, 1, bt, PCWE | RET | (bt ? SEL1 : '0)); len++;
      return;
    end
    cyc(1, 1, 1, bt, '0); len++;
    if (op == LD || op == ST) begin
      for (int k = 0; k < wd; k++) begin cyc(1, 1, 0, 0, DREQ | (op == ST ? DWE : '0)); len++; end
      if (op == ST) begin
        cyc(1, 1, 1, 0, DREQ | DWE | PCWE | RET); len++;
        return;
      end
      cyc(1, 1, 1, 0, DREQ | MDR); len++;
    end
    cyc(1, 1, 1, 0, RF | PCWE | RET | (op == JAL ? SEL1 : op == JALR ? SEL2 : '0)); len++;
  endtask
  task automatic pin(input int i, input int len_exp);
    nxt_i = i;
    nxt_n = len_exp;
    nxt_act = n;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    cnt = '0;
    cyc(0, 1, 1, 0, '0);
    nxt_i = 0;
    cyc(1, 1, 1, 0, '0);
    instr(ALU, 0, 0, 0, n);   pin(1, 4);
    instr(LD, 0, 2, 0, n);    pin(2, 7);
    instr(BR, 0, 0, 1, n);    pin(3, 3);
    instr(BR, 0, 0, 0, n);
    instr(JALR, 0, 0, 0, n);  pin(5, 4);
    instr(JAL, 1, 0, 0, n);   pin(6, 5);
    instr(LUI, 0, 0, 0, n);
    instr(AUIPC, 2, 0, 0, n);
    instr(ALUI, 0, 0, 0, n);
    instr(ST, 0, 0, 0, n);    pin(10, 4);
    instr(ST, 0, 1, 0, n);    pin(11, 5);
    instr(LD, 1, 0, 0, n);    pin(12, 6);
    instr(SYS, 0, 0, 0, n);
    for (int k = 0; k < 20; k++) cyc(1, 1, 1, 1, HLT);
    nxt_i = 12;
    cyc(0, 1, 1, 0, HLT);
    cnt = '0;
    nxt_i = 0;
    cyc(1, 1, 1, 0, '0);
    instr(ALU, 0, 0, 0, n);
    cur_op = LD;
    cyc(1, 1, 0, 0, IREQ | IRWE);
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, DREQ);
    nxt_i = 1;
    cyc(0, 0, 0, 0, DREQ);
    cnt = '0;
    nxt_i = 0;
    cyc(1, 0, 1, 0, '0);
    instr(ALU, 0, 0, 0, n);
    for (int k = 0; k < 14; k++) instr(BR, 0, 0, k[0], n);
    nxt_i = 15;
    instr(ALU, 0, 0, 0, n);
    nxt_i = 0;
    cyc(1, 0, 0, 0, IREQ);
    @(posedge clk);
    #1;
    chk_en = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the instruction/data memory request handshakes and issues write-enable strobes to the IR, PC and register file. It also selects the next-PC source, counts retired instructions, and halts on unsupported opcodes. It sits beside the decode stage, consuming its `opcode`, and owns all datapath sequencing.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `opcode`  in  7  `instr[6:0]` from decode; valid from DECODE onward; IR is stable until next FETCH.
- `br_taken`  in  1  ALU branch-compare result; valid in EXEC.
- `imem_req`  out  1  instruction fetch request.
- `imem_ready`  in  1  fetch completes in the cycle it is high while `imem_req` is high.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  1 = store, 0 = load; qualified by `dmem_req`.
- `dmem_ready`  in  1  data access completes in the cycle it is high while `dmem_req` is high.
- `ir_we`  out  1  latch `imem_rdata` into IR.
- `mdr_we`  out  1  latch load data.
- `rf_we`  out  1  register-file write strobe.
- `pc_we`  out  1  PC update strobe.
- `pc_sel`  out  2  PC source: 00 = PC+4, 01 = PC+imm (branch/JAL), 10 = (rs1+imm)&~1 (JALR).
- `retire`  out  1  one-cycle pulse per completed instruction.
- `instret`  out  CNT_W  retired count; wraps to 0.
- `halted`  out  1  sticky; set on an unsupported opcode.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - Encoding lives in the package.
  - Register resets to IDLE.
- IDLE → FETCH unconditionally. All outputs are 0 in IDLE.
- FETCH: `imem_req` = 1.
  - When `imem_ready` is seen: `ir_we` = 1, go to DECODE.
  - Otherwise hold; `imem_req` stays high.
- DECODE: one cycle for register-file read.
  - Legal opcodes go to EXEC.
  - Any other opcode goes to HALT. This includes FENCE and SYSTEM.
- EXEC, by opcode:
  - ALU, ALUI, LUI, AUIPC: go to WB.
  - JAL, JALR: go to WB. Link value is PC+4.
  - LOAD, STORE: go to MEM.
  - BRANCH: `pc_we` = 1, `retire` = 1, go to FETCH. `pc_sel` = 01 if `br_taken`, else 00.
- MEM: `dmem_req` = 1, `dmem_we` = (opcode == STORE).
  - On `dmem_ready`, STORE: `pc_we` = 1, `pc_sel` = 00, `retire` = 1, go to FETCH.
  - On `dmem_ready`, LOAD: `mdr_we` = 1, go to WB.
  - Otherwise hold with the request asserted.
- WB: `rf_we` = 1, `pc_we` = 1, `retire` = 1, go to FETCH.
  - `pc_sel` = 01 for JAL, 10 for JALR, 00 otherwise.
- HALT: absorbing. `halted` = 1; all strobes and requests are 0. Exit only by reset.
- `instret` increments by 1 on each `retire`. It wraps from 2^CNT_W−1 to 0.
- The opcode is sampled combinationally in DECODE, EXEC, MEM and WB; it is not re-latched.

## Timing
- Reset values: state = IDLE; `instret` = 0; `halted` = 0. Every strobe and request output is 0.
- Output types:
  - Requests, `dmem_we`, `pc_sel` and `halted` are Moore outputs decoded from the state.
  - `ir_we`, `mdr_we`, and the `pc_we`/`retire` pulses issued in MEM are Mealy: request && ready.
- `imem_req` first rises in the cycle after reset is released (IDLE, then FETCH).
- Latency with zero-wait memory (ready high in the first request cycle):
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle on either memory adds exactly 1 cycle.
- A ready seen without a request is ignored.
- The request is never dropped before ready. No new request is issued in the cycle after a completion; the next state does not request the same memory.
- Reset mid-operation: at the next edge the state goes to IDLE and outputs go to 0, and `instret` clears. The in-flight instruction does not retire.
- `halted` asserts on the edge leaving DECODE with an illegal opcode. `retire` does not pulse for that instruction.

## Structure
- Shared package `core_pkg`:
  - RV32I opcode constants: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ALUI 0010011, ALU 0110011.
  - `seq_state_t` enum.
  - `pc_sel` encodings.
- Single module; no sub-module. The retire counter is inline.

## Test plan
- Reset, then ALU opcode 0110011, ready always 1:
  - `imem_req` high in cycle 1, `ir_we` in cycle 1.
  - `rf_we`, `pc_we` and `retire` in cycle 4 with `pc_sel` = 00; `instret` = 1.
- LOAD with `dmem_ready` delayed 2 cycles:
  - `dmem_req` held 3 cycles with `dmem_we` = 0.
  - `mdr_we` in the 3rd cycle, then WB; total 7 cycles.
- BRANCH:
  - With `br_taken` = 1: `pc_sel` = 01 and `retire` in EXEC, no `rf_we`.
  - With `br_taken` = 0: `pc_sel` = 00.
- JALR: WB shows `pc_sel` = 10 with `rf_we` = 1. STORE: `dmem_we` = 1 and retire in MEM, never `rf_we`.
- Opcode 1110011: `halted` = 1 after DECODE; no requests for 20 further cycles; `instret` unchanged; reset clears `halted`.
- `rst_n` low during the MEM wait: `dmem_req` is 0 next cycle, `instret` = 0, and the restart begins with IDLE then FETCH. Preload `instret` near all-ones (CNT_W = 4): wraps 15 → 0.
